// File: rtl/player_life_controller.sv
// Player life/hit controller: tracks lives, freezes the player after a hit,
// then blinks the sprite through a post-hit invulnerability window.
module player_life_controller #(
    parameter int START_LIVES   = 3,
    parameter int HIT_FRAMES    = 60,
    parameter int INVULN_FRAMES = 90,
    parameter int BLINK_LOG2    = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       standBy,
    input  logic       gameEnded,
    input  logic       collisionAlienShot_Player,
    output logic [2:0] livesLeft,
    output logic       playerVisible,
    output logic       playerFreeze,
    output logic       lifeLost,
    output logic       gameLose
);

    localparam int CNT_MAX  = (HIT_FRAMES > INVULN_FRAMES) ? HIT_FRAMES : INVULN_FRAMES;
    localparam int CNT_BITS = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    // Counter must be wide enough to expose the blink bit even for short windows.
    localparam int CNT_W    = (CNT_BITS > BLINK_LOG2) ? CNT_BITS : BLINK_LOG2 + 1;

    localparam logic [2:0]       LIVES_INIT = 3'(START_LIVES);
    localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_FRAMES - 1);
    localparam logic [CNT_W-1:0] INV_LAST   = CNT_W'(INVULN_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ALIVE,
        HIT,
        INVULN,
        DEAD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] frame_cnt_nxt;
    logic [2:0]       lives_nxt;
    logic             visible_nxt;
    logic             freeze_nxt;
    logic             lost_nxt;
    logic             lose_nxt;
    logic             play_game;

    always_comb play_game = !(standBy || gameEnded);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            frame_cnt     <= '0;
            livesLeft     <= LIVES_INIT;
            playerVisible <= 1'b1;
            playerFreeze  <= 1'b1;
            lifeLost      <= 1'b0;
            gameLose      <= 1'b0;
        end else begin
            state         <= state_nxt;
            frame_cnt     <= frame_cnt_nxt;
            livesLeft     <= lives_nxt;
            playerVisible <= visible_nxt;
            playerFreeze  <= freeze_nxt;
            lifeLost      <= lost_nxt;
            gameLose      <= lose_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        lives_nxt     = livesLeft;
        lost_nxt      = 1'b0;

        case (state)
            IDLE: begin
                lives_nxt     = LIVES_INIT;
                frame_cnt_nxt = '0;
                if (startOfFrame && play_game)
                    state_nxt = ALIVE;
            end
            ALIVE: begin
                // Leaving the game takes priority over a coincident hit.
                if (!play_game) begin
                    state_nxt     = IDLE;
                    lives_nxt     = LIVES_INIT;
                    frame_cnt_nxt = '0;
                end else if (collisionAlienShot_Player) begin
                    lost_nxt      = 1'b1;
                    frame_cnt_nxt = '0;
                    if (livesLeft > 3'd1) begin
                        lives_nxt = livesLeft - 3'd1;
                        state_nxt = HIT;
                    end else begin
                        lives_nxt = 3'd0;
                        state_nxt = DEAD;
                    end
                end
            end
            HIT: begin
                if (!play_game) begin
                    state_nxt     = IDLE;
                    lives_nxt     = LIVES_INIT;
                    frame_cnt_nxt = '0;
                end else if (startOfFrame) begin
                    if (frame_cnt == HIT_LAST) begin
                        state_nxt     = INVULN;
                        frame_cnt_nxt = '0;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 1'b1;
                    end
                end
            end
            INVULN: begin
                if (!play_game) begin
                    state_nxt     = IDLE;
                    lives_nxt     = LIVES_INIT;
                    frame_cnt_nxt = '0;
                end else if (startOfFrame) begin
                    if (frame_cnt == INV_LAST) begin
                        state_nxt     = ALIVE;
                        frame_cnt_nxt = '0;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 1'b1;
                    end
                end
            end
            DEAD: begin
                lives_nxt = 3'd0;
                if (standBy) begin
                    state_nxt     = IDLE;
                    lives_nxt     = LIVES_INIT;
                    frame_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt     = IDLE;
                lives_nxt     = LIVES_INIT;
                frame_cnt_nxt = '0;
            end
        endcase

        // Sprite controls are decoded from the upcoming state so they stay registered.
        visible_nxt = 1'b1;
        freeze_nxt  = 1'b1;
        lose_nxt    = 1'b0;
        case (state_nxt)
            ALIVE:   freeze_nxt = 1'b0;
            INVULN: begin
                freeze_nxt  = 1'b0;
                visible_nxt = !frame_cnt_nxt[BLINK_LOG2];
            end
            DEAD: begin
                visible_nxt = 1'b0;
                lose_nxt    = 1'b1;
            end
            default: begin
                visible_nxt = 1'b1;
                freeze_nxt  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_player_life_controller.sv
// Randomised and directed bench for player_life_controller against a
// frame-counting reference model of the lives/hit/invulnerability rules.
module tb_player_life_controller;

    localparam int START_LIVES   = 3;
    localparam int HIT_FRAMES    = 60;
    localparam int INVULN_FRAMES = 90;
    localparam int BLINK_LOG2    = 3;

    logic       clk = 1'b0;
    logic       resetN;
    logic       sof;
    logic       sb;
    logic       ge;
    logic       col;
    logic [2:0] livesLeft;
    logic       playerVisible;
    logic       playerFreeze;
    logic       lifeLost;
    logic       gameLose;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: mode 0 = menu, 1 = playing, 2 = game over.
    // While playing, fsh < 0 means vulnerable; otherwise frames since the last hit.
    int m_mode;
    int m_lives;
    int m_fsh;
    bit m_lost;

    player_life_controller #(
        .START_LIVES  (START_LIVES),
        .HIT_FRAMES   (HIT_FRAMES),
        .INVULN_FRAMES(INVULN_FRAMES),
        .BLINK_LOG2   (BLINK_LOG2)
    ) dut (
        .clk                      (clk),
        .resetN                   (resetN),
        .startOfFrame             (sof),
        .standBy                  (sb),
        .gameEnded                (ge),
        .collisionAlienShot_Player(col),
        .livesLeft                (livesLeft),
        .playerVisible            (playerVisible),
        .playerFreeze             (playerFreeze),
        .lifeLost                 (lifeLost),
        .gameLose                 (gameLose)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode  = 0;
        m_lives = START_LIVES;
        m_fsh   = -1;
        m_lost  = 1'b0;
    endfunction

    function automatic void model_step();
        bit playing;
        playing = !(sb || ge);
        m_lost  = 1'b0;
        if (m_mode == 0) begin
            m_lives = START_LIVES;
            if (sof && playing) begin
                m_mode = 1;
                m_fsh  = -1;
            end
        end else if (m_mode == 2) begin
            if (sb) begin
                m_mode  = 0;
                m_lives = START_LIVES;
            end
        end else if (!playing) begin
            m_mode  = 0;
            m_lives = START_LIVES;
        end else if (m_fsh < 0) begin
            if (col) begin
                m_lost  = 1'b1;
                m_lives = m_lives - 1;
                if (m_lives == 0) m_mode = 2;
                else m_fsh = 0;
            end
        end else if (sof) begin
            m_fsh = m_fsh + 1;
            if (m_fsh == HIT_FRAMES + INVULN_FRAMES) m_fsh = -1;
        end
    endfunction

    function automatic logic [6:0] exp_vec();
        logic [2:0] l;
        l = 3'(m_lives);
        if (m_mode == 0) return {3'(START_LIVES), 1'b1, 1'b1, m_lost, 1'b0};
        if (m_mode == 2) return {3'd0, 1'b0, 1'b1, m_lost, 1'b1};
        if (m_fsh < 0) return {l, 1'b1, 1'b0, m_lost, 1'b0};
        if (m_fsh < HIT_FRAMES) return {l, 1'b1, 1'b1, m_lost, 1'b0};
        return {l, (((m_fsh - HIT_FRAMES) / (1 << BLINK_LOG2)) % 2) == 0, 1'b0, m_lost, 1'b0};
    endfunction

    function automatic logic [6:0] obs_vec();
        return {livesLeft, playerVisible, playerFreeze, lifeLost, gameLose};
    endfunction

    task automatic tick(input logic s, input logic c);
        sof = s;
        col = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        sof = 1'b0; sb = 1'b0; ge = 1'b0; col = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        if (obs_vec() !== {3'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b", obs_vec(), {3'd3, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        checks++;
        tick(1'b0, 1'b1);
        if (obs_vec() !== {3'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL idle_ignores_collision got=%b want=%b", obs_vec(), {3'd3, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        checks++;
    endtask

    task automatic test_start();
        tick(1'b1, 1'b0);
        if (obs_vec() !== {3'd3, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL start_alive got=%b want=%b", obs_vec(), {3'd3, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        checks++;
    endtask

    task automatic test_single_hit();
        int pulses = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1'b0, 1'b1);
            if (lifeLost === 1'b1) pulses++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                if (errors < 30) $display("FAIL single_hit_hold cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
            end
            checks++;
        end
        if (pulses !== 1) begin
            errors++;
            $display("FAIL single_hit_pulses got=%0d want=1", pulses);
        end
        checks++;
        if (livesLeft !== 3'd2) begin
            errors++;
            $display("FAIL single_hit_lives got=%0d want=2", livesLeft);
        end
        checks++;
        for (int f = 0; f < HIT_FRAMES + INVULN_FRAMES + 2; f++) begin
            for (int k = 0; k < 4; k++) begin
                tick(k == 0, 1'b0);
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    if (errors < 30) $display("FAIL hit_invuln_seq cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
                end
                checks++;
            end
        end
        if (obs_vec() !== {3'd2, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL back_to_alive got=%b want=%b", obs_vec(), {3'd2, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        checks++;
    endtask

    task automatic test_sof_with_hit();
        // Hit coinciding with a frame start: that frame must not count.
        tick(1'b1, 1'b1);
        for (int f = 0; f < HIT_FRAMES - 1; f++) begin
            tick(1'b0, 1'b0);
            tick(1'b1, 1'b0);
        end
        if (playerFreeze !== 1'b1) begin
            errors++;
            $display("FAIL sof_hit_still_frozen got=%b want=1", playerFreeze);
        end
        checks++;
        tick(1'b1, 1'b0);
        if (obs_vec() !== {3'd1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sof_hit_invuln_entry got=%b want=%b", obs_vec(), {3'd1, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        checks++;
    endtask

    task automatic test_invuln_hold();
        int pulses = 0;
        do_reset();
        tick(1'b1, 1'b0);
        for (int f = 0; f < HIT_FRAMES + INVULN_FRAMES + 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                tick(k == 1, 1'b1);
                if (lifeLost === 1'b1) pulses++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    if (errors < 30) $display("FAIL invuln_hold cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
                end
                checks++;
            end
        end
        if (pulses !== 2 || livesLeft !== 3'd1) begin
            errors++;
            $display("FAIL invuln_hold_pulses got=%0d/%0d want=2/1", pulses, livesLeft);
        end
        checks++;
    endtask

    task automatic test_game_over();
        int pulses = 0;
        for (int f = 0; f < HIT_FRAMES + INVULN_FRAMES + 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                tick(k == 2, 1'b1);
                if (lifeLost === 1'b1) pulses++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    if (errors < 30) $display("FAIL game_over_seq cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
                end
                checks++;
            end
        end
        if (obs_vec() !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b1} || pulses !== 1) begin
            errors++;
            $display("FAIL game_over_state got=%b/%0d want=%b/1", obs_vec(), pulses, {3'd0, 1'b0, 1'b1, 1'b0, 1'b1});
        end
        checks++;
        sb = 1'b1;
        tick(1'b0, 1'b0);
        sb = 1'b0;
        if (obs_vec() !== {3'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL standby_restore got=%b want=%b", obs_vec(), {3'd3, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        checks++;
    endtask

    task automatic test_abort();
        tick(1'b1, 1'b0);
        ge = 1'b1;
        tick(1'b0, 1'b1);
        if (obs_vec() !== {3'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_with_hit got=%b want=%b", obs_vec(), {3'd3, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        checks++;
        ge = 1'b0;
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_hit();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        for (int f = 0; f < 30; f++) begin
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end
        if (obs_vec() !== {3'd2, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_hit_state got=%b want=%b", obs_vec(), {3'd2, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        checks++;
        #3;
        resetN = 1'b0;
        model_reset();
        #1;
        if (obs_vec() !== {3'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got=%b want=%b", obs_vec(), {3'd3, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        checks++;
        @(negedge clk);
        resetN = 1'b1;
        tick(1'b1, 1'b0);
        if (obs_vec() !== {3'd3, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fresh_after_reset got=%b want=%b", obs_vec(), {3'd3, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        checks++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 8000; i++) begin
            sb = ($urandom_range(0, 299) == 0);
            ge = ($urandom_range(0, 499) == 0);
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                if (errors < 30) $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
            end
            checks++;
        end
        sb = 1'b0;
        ge = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_single_hit();
        test_sof_with_hit();
        test_invuln_hold();
        test_game_over();
        test_abort();
        test_reset_mid_hit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player_life_controller.md
PLAYER_LIFE_CONTROLLER -- requirements
Module: player_life_controller

Interface
REQ-001 Parameter START_LIVES, default 3, lives granted at game start (range 1..7).
REQ-002 Parameter HIT_FRAMES, default 60, frames the player is frozen after a hit (>=1).
REQ-003 Parameter INVULN_FRAMES, default 90, frames of post-hit invulnerability (>=1).
REQ-004 Parameter BLINK_LOG2, default 3, blink half-period of 2^BLINK_LOG2 frames during invulnerability.
REQ-005 clk  input  1  system clock; the single clock domain.
REQ-006 resetN  input  1  reset, asynchronous and active-low.
REQ-007 startOfFrame  input  1  one-cycle pulse at each frame start.
REQ-008 standBy  input  1  game in standby/menu.
REQ-009 gameEnded  input  1  game finished (win path).
REQ-010 collisionAlienShot_Player  input  1  alien shot overlaps player pixel; may be high for many cycles per frame.
REQ-011 livesLeft  output  3  current life count for the life-bar display.
REQ-012 playerVisible  output  1  player sprite draw enable (blink control).
REQ-013 playerFreeze  output  1  player movement and firing inhibited.
REQ-014 lifeLost  output  1  one-cycle pulse per accepted hit.
REQ-015 gameLose  output  1  level signal; last life lost.

Function
REQ-016 playGame SHALL equal NOT(standBy OR gameEnded), evaluated combinationally each cycle.
REQ-017 FSM states SHALL be IDLE, ALIVE, HIT, INVULN, DEAD; frameCnt is a counter sized for max(HIT_FRAMES, INVULN_FRAMES), advanced only on startOfFrame.
REQ-018 IDLE: livesLeft=START_LIVES, playerVisible=1, playerFreeze=1, gameLose=0; on startOfFrame with playGame=1 -> ALIVE next cycle.
REQ-019 ALIVE: playerVisible=1, playerFreeze=0; first cycle with collision=1 is an accepted hit.
REQ-020 Accepted hit SHALL register next cycle: lifeLost=1 for exactly one cycle, livesLeft decremented by 1, frameCnt=0; next state HIT if pre-hit livesLeft>1, else DEAD.
REQ-021 Only one hit SHALL be accepted per ALIVE entry; collisions in HIT, INVULN, DEAD, IDLE are ignored.
REQ-022 HIT: playerFreeze=1, playerVisible=1; frameCnt increments on each startOfFrame; on startOfFrame with frameCnt==HIT_FRAMES-1 -> INVULN, frameCnt=0.
REQ-023 INVULN: playerFreeze=0; playerVisible = NOT frameCnt[BLINK_LOG2]; on startOfFrame with frameCnt==INVULN_FRAMES-1 -> ALIVE, frameCnt=0.
REQ-024 DEAD: livesLeft=0, gameLose=1, playerFreeze=1, playerVisible=0; held until standBy=1, then -> IDLE.
REQ-025 In ALIVE, HIT, INVULN: playGame=0 SHALL force IDLE next cycle, restoring livesLeft=START_LIVES and clearing frameCnt.
REQ-026 Simultaneous playGame=0 and collision in ALIVE: abort wins; no lifeLost pulse, no decrement.
REQ-027 Simultaneous collision and startOfFrame in ALIVE: hit accepted; frameCnt starts at 0 (startOfFrame not counted).
REQ-028 livesLeft SHALL never underflow below 0 nor exceed START_LIVES.
REQ-029 All outputs SHALL be registered; no output depends combinationally on inputs.

Reset
REQ-030 resetN=0 SHALL asynchronously force IDLE, livesLeft=START_LIVES, frameCnt=0, lifeLost=0, gameLose=0, playerVisible=1, playerFreeze=1.
REQ-031 Reset asserted mid-HIT or mid-DEAD SHALL discard all progress; first frame after release behaves as fresh IDLE.

Verification
REQ-032 Start: reset, standBy=0, gameEnded=0, one startOfFrame -> ALIVE, livesLeft=3, playerFreeze=0.
REQ-033 Single hit: collision high 200 cycles in ALIVE -> exactly one lifeLost pulse, livesLeft=2, HIT for 60 frames, then INVULN with playerVisible toggling every 8 frames for 90 frames, then ALIVE.
REQ-034 Invulnerability: collision held continuously through HIT and INVULN -> no further lifeLost; second hit accepted only on first ALIVE cycle.
REQ-035 Game over: three accepted hits -> livesLeft 3->2->1->0, gameLose=1 after third; assert standBy -> IDLE, livesLeft=3, gameLose=0.
REQ-036 Abort: gameEnded=1 in same cycle as collision in ALIVE -> no lifeLost, IDLE next cycle, livesLeft=3.
REQ-037 Reset mid-operation: resetN low during HIT frame 30 -> outputs at REQ-030 values immediately, without waiting for a clock edge.
